// File: rtl/sync_w2r_gray.sv
// Write-pointer synchroniser for the asynchronous FIFO read domain.
// Carries the Gray write pointer through a SYNC_STAGES-deep flop chain into
// rclk, converts it to binary and reports the per-cycle advance plus a sticky
// flag for pointer jumps larger than the FIFO depth.
//
// Ports:
//   rclk       read-domain clock
//   rrst_n     asynchronous active-low reset
//   wptr       Gray write pointer from the write domain (asynchronous)
//   rq_wptr    synchronised Gray pointer (last chain stage)
//   rq_wbin    registered binary form of rq_wptr
//   rq_wdelta  entries written since the previous cycle (mod 2**(ADDRSIZE+1))
//   rq_wchg    one-cycle pulse when rq_wbin changes
//   rq_werr    sticky: a jump larger than DEPTH was observed
module sync_w2r_gray #(
  parameter int unsigned ADDRSIZE    = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [ADDRSIZE:0]   wptr,
  output logic [ADDRSIZE:0]   rq_wptr,
  output logic [ADDRSIZE:0]   rq_wbin,
  output logic [ADDRSIZE:0]   rq_wdelta,
  output logic                rq_wchg,
  output logic                rq_werr
);

  localparam int unsigned PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {ADDRSIZE{1'b0}}};

  // Reject chain depths outside 2..4 at elaboration.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("sync_w2r_gray: SYNC_STAGES must be in 2..4");
  end

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wdelta_q, wdelta_d;
  logic          wchg_q, wchg_d;
  logic          werr_q, werr_d;
  logic [PW-1:0] nbin;

  // Synchroniser chain, no logic between stages.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      for (int k = 0; k < int'(SYNC_STAGES); k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= wptr;
      for (int k = 1; k < int'(SYNC_STAGES); k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign rq_wptr = sync_q[SYNC_STAGES-1];

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    nbin = '0;
    for (int i = 0; i < int'(PW); i++) begin
      nbin[i] = ^(rq_wptr >> i);
    end
  end

  // Next-state for the registered binary view; subtraction wraps at pointer width.
  always_comb begin
    wbin_d   = nbin;
    wdelta_d = nbin - wbin_q;
    wchg_d   = (nbin != wbin_q);
    werr_d   = werr_q | (wdelta_d > DEPTH);
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      wbin_q   <= '0;
      wdelta_q <= '0;
      wchg_q   <= 1'b0;
      werr_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wdelta_q <= wdelta_d;
      wchg_q   <= wchg_d;
      werr_q   <= werr_d;
    end
  end

  assign rq_wbin   = wbin_q;
  assign rq_wdelta = wdelta_q;
  assign rq_wchg   = wchg_q;
  assign rq_werr   = werr_q;

endmodule

// File: tb/tb_sync_w2r_gray.sv
// Directed bench for sync_w2r_gray with ADDRSIZE=4 and chain depths 2, 3, 4.
module tb_sync_w2r_gray;

  logic       rclk = 1'b0;
  logic       rrst_n;
  logic [4:0] wptr;

  logic [4:0] p2, b2, d2;  logic c2, e2;
  logic [4:0] p3, b3, d3;  logic c3, e3;
  logic [4:0] p4, b4, d4;  logic c4, e4;

  int total = 0;
  int bad   = 0;

  always #5 rclk = ~rclk;

  sync_w2r_gray #(.ADDRSIZE(4), .SYNC_STAGES(2)) u2 (
    .rclk(rclk), .rrst_n(rrst_n), .wptr(wptr),
    .rq_wptr(p2), .rq_wbin(b2), .rq_wdelta(d2), .rq_wchg(c2), .rq_werr(e2));
  sync_w2r_gray #(.ADDRSIZE(4), .SYNC_STAGES(3)) u3 (
    .rclk(rclk), .rrst_n(rrst_n), .wptr(wptr),
    .rq_wptr(p3), .rq_wbin(b3), .rq_wdelta(d3), .rq_wchg(c3), .rq_werr(e3));
  sync_w2r_gray #(.ADDRSIZE(4), .SYNC_STAGES(4)) u4 (
    .rclk(rclk), .rrst_n(rrst_n), .wptr(wptr),
    .rq_wptr(p4), .rq_wbin(b4), .rq_wdelta(d4), .rq_wchg(c4), .rq_werr(e4));

  // Observed outputs of the 2-stage instance: {rq_wptr, rq_wbin, rq_wdelta, rq_wchg, rq_werr}
  logic [16:0] obs;
  assign obs = {p2, b2, d2, c2, e2};

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge rclk);
      #1;
    end
  endtask

  task automatic do_reset(input logic [4:0] w);
    rrst_n = 1'b0;
    wptr   = w;
    tick(2);
    rrst_n = 1'b1;
  endtask

  task automatic test_reset;
    logic [16:0] exp;
    rrst_n = 1'b0;
    wptr   = 5'b10001;
    #1;
    exp = '0;
    total++;
    if (obs !== exp) begin bad++; $display("FAIL reset_async got=%b exp=%b", obs, exp); end
    tick(2);
    total++;
    if (obs !== exp) begin bad++; $display("FAIL reset_held got=%b exp=%b", obs, exp); end
    rrst_n = 1'b1;
    tick(2);
    exp = {5'b10001, 5'd0, 5'd0, 1'b0, 1'b0};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL reset_ptr_2edges got=%b exp=%b", obs, exp); end
    tick(1);
    exp = {5'b10001, 5'd30, 5'd30, 1'b1, 1'b1};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL reset_jump_from0 got=%b exp=%b", obs, exp); end
  endtask

  task automatic test_single_step;
    logic [16:0] exp;
    do_reset(5'b00000);
    tick(2);
    wptr = 5'b00001;
    tick(2);
    exp = {5'b00001, 5'd0, 5'd0, 1'b0, 1'b0};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL single_ptr got=%b exp=%b", obs, exp); end
    tick(1);
    exp = {5'b00001, 5'd1, 5'd1, 1'b1, 1'b0};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL single_bin got=%b exp=%b", obs, exp); end
    tick(1);
    exp = {5'b00001, 5'd1, 5'd0, 1'b0, 1'b0};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL single_settle got=%b exp=%b", obs, exp); end
  endtask

  // Continues from bin 1 left by test_single_step.
  task automatic test_multi_step;
    logic [16:0] exp;
    wptr = 5'b00111;
    tick(3);
    exp = {5'b00111, 5'd5, 5'd4, 1'b1, 1'b0};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL multi_jump got=%b exp=%b", obs, exp); end
    tick(1);
    exp = {5'b00111, 5'd5, 5'd0, 1'b0, 1'b0};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL multi_pulse_end got=%b exp=%b", obs, exp); end
  endtask

  // Legal walk 5 -> 13 -> 21 -> 29 -> 30, then wrap to 2.
  task automatic test_wrap;
    logic [4:0]  gray_tab [4] = '{5'b01011, 5'b11111, 5'b10011, 5'b10001};
    logic [4:0]  bin_tab  [4] = '{5'd13, 5'd21, 5'd29, 5'd30};
    logic [4:0]  dlt_tab  [4] = '{5'd8, 5'd8, 5'd8, 5'd1};
    logic [16:0] exp;
    for (int i = 0; i < 4; i++) begin
      wptr = gray_tab[i];
      tick(3);
      exp = {gray_tab[i], bin_tab[i], dlt_tab[i], 1'b1, 1'b0};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL walk_%0d got=%b exp=%b", i, obs, exp); end
    end
    wptr = 5'b00011;
    tick(3);
    exp = {5'b00011, 5'd2, 5'd4, 1'b1, 1'b0};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL wrap got=%b exp=%b", obs, exp); end
  endtask

  task automatic test_depth_boundary;
    logic [16:0] exp;
    do_reset(5'b00000);
    tick(2);
    wptr = 5'b11000;
    tick(3);
    exp = {5'b11000, 5'd16, 5'd16, 1'b1, 1'b0};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL jump_eq_depth got=%b exp=%b", obs, exp); end
  endtask

  task automatic test_illegal_jump;
    logic [16:0] exp;
    do_reset(5'b00000);
    tick(2);
    wptr = 5'b11110;
    tick(3);
    exp = {5'b11110, 5'd20, 5'd20, 1'b1, 1'b1};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL illegal_jump got=%b exp=%b", obs, exp); end
    wptr = 5'b11111;
    tick(3);
    exp = {5'b11111, 5'd21, 5'd1, 1'b1, 1'b1};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL err_sticky got=%b exp=%b", obs, exp); end
    tick(1);
    exp = {5'b11111, 5'd21, 5'd0, 1'b0, 1'b1};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL err_sticky_idle got=%b exp=%b", obs, exp); end
    rrst_n = 1'b0;
    #1;
    exp = '0;
    total++;
    if (obs !== exp) begin bad++; $display("FAIL err_reset_clear got=%b exp=%b", obs, exp); end
    wptr = 5'b00000;
    tick(1);
    rrst_n = 1'b1;
    tick(3);
    total++;
    if (obs !== exp) begin bad++; $display("FAIL err_after_reset got=%b exp=%b", obs, exp); end
  endtask

  task automatic test_depth_sweep;
    int lat2 = 0;
    int lat3 = 0;
    int lat4 = 0;
    do_reset(5'b00000);
    tick(2);
    wptr = 5'b00001;
    for (int e = 1; e <= 8; e++) begin
      tick(1);
      if (lat2 == 0 && b2 == 5'd1) lat2 = e;
      if (lat3 == 0 && b3 == 5'd1) lat3 = e;
      if (lat4 == 0 && b4 == 5'd1) lat4 = e;
    end
    total++;
    if (lat2 !== 3) begin bad++; $display("FAIL latency_s2 got=%0d exp=3", lat2); end
    total++;
    if (lat3 !== 4) begin bad++; $display("FAIL latency_s3 got=%0d exp=4", lat3); end
    total++;
    if (lat4 !== 5) begin bad++; $display("FAIL latency_s4 got=%0d exp=5", lat4); end
    total++;
    if ({b4, d4, e4} !== {5'd1, 5'd0, 1'b0}) begin
      bad++; $display("FAIL s4_final got=%0d/%0d/%0d exp=1/0/0", b4, d4, e4);
    end
  endtask

  initial begin
    rrst_n = 1'b0;
    wptr   = '0;
    tick(1);
    test_reset;
    test_single_step;
    test_multi_step;
    test_wrap;
    test_depth_boundary;
    test_illegal_jump;
    test_depth_sweep;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_w2r_gray.md
# sync_w2r_gray

Parametrised write-pointer synchroniser for the asynchronous FIFO read domain. It carries the Gray-coded write pointer through a configurable-depth flop chain into the read clock domain, then produces a registered binary pointer. It also reports how many entries were written since the previous read-clock cycle and flags pointer jumps that no legal writer can produce. It replaces the fixed two-flop synchroniser on the read side and feeds the empty/level logic directly.

## Interface
- ADDRSIZE, 8, FIFO address width; pointers are ADDRSIZE+1 bits (wrap bit included); DEPTH = 2**ADDRSIZE.
- SYNC_STAGES, 2, number of synchroniser flops; legal range 2..4; any other value is an elaboration error.
- rclk  input  1  read-domain clock; all state updates on its rising edge.
- rrst_n  input  1  asynchronous active-low reset; clears all state immediately.
- wptr  input  ADDRSIZE+1  Gray-coded write pointer from the write domain, asynchronous to rclk.
- rq_wptr  output  ADDRSIZE+1  synchronised Gray pointer (last stage of chain).
- rq_wbin  output  ADDRSIZE+1  binary equivalent of rq_wptr, registered.
- rq_wdelta  output  ADDRSIZE+1  entries written since the previous cycle, modulo 2**(ADDRSIZE+1).
- rq_wchg  output  1  single-cycle pulse: rq_wbin changed this cycle.
- rq_werr  output  1  sticky error: an impossible pointer jump was seen.

## Operation
- Reset (rrst_n low, asynchronous): every stage flop, rq_wptr, rq_wbin, rq_wdelta, rq_wchg and rq_werr go to 0. They stay at 0 while reset is held. Reset mid-operation discards all in-flight samples; there is no partial-state retention.
- Sync chain: s1 <= wptr; sk <= s(k-1) for k = 2..SYNC_STAGES; rq_wptr = s(SYNC_STAGES). No logic sits between stages.
- Gray-to-binary: b[MSB] = g[MSB]; b[i] = b[i+1] XOR g[i]. It is computed combinationally from rq_wptr and called nbin.
- Registered outputs, each rclk edge:
  - rq_wbin <= nbin.
  - rq_wdelta <= (nbin - rq_wbin) mod 2**(ADDRSIZE+1). This is unsigned subtraction at pointer width; wrap-around is handled naturally.
  - rq_wchg <= (nbin != rq_wbin).
  - rq_werr <= rq_werr OR ((nbin - rq_wbin) mod 2**(ADDRSIZE+1) > DEPTH).
- rq_werr clears only on reset.
- Multi-step jumps of up to DEPTH are legal, because a faster write clock can advance several entries between rclk samples. Such jumps are reported in rq_wdelta and do not set rq_werr.
- The block has no back-pressure or handshake. The consumer samples the outputs every cycle. rq_wchg is never held high for more than one cycle unless the pointer changes on consecutive cycles.

## Timing
- A wptr change that meets setup before rclk edge t appears on rq_wptr after edge t+SYNC_STAGES-1, i.e. SYNC_STAGES edges counting edge t.
- rq_wbin, rq_wdelta and rq_wchg update one edge after rq_wptr. Total latency is SYNC_STAGES+1 edges.
- If wptr changes within the metastability window of edge t, the new value may instead appear one edge later. The bench must accept either and never see a value that is not the old or new Gray code.
- rq_wdelta holds its last value when rq_wchg = 0; that value is 0 after any no-change cycle.
- First cycle after reset release: rq_wbin = 0, rq_wdelta = 0, rq_wchg = 0. A non-zero wptr at release is treated as a jump from 0.

## Test plan
All scenarios use ADDRSIZE=4 and SYNC_STAGES=2 unless stated.
- Reset: drive wptr = 5'b10001 with rrst_n low → all outputs 0. Release → rq_wptr = 10001 after 2 edges; rq_wbin = 30, rq_wdelta = 30, rq_werr = 1 after 3 edges (jump from 0 > 16).
- Single step: from reset, set wptr = 00001 (bin 1) at edge t → rq_wptr = 00001 after edge t+1. At edge t+2: rq_wbin = 1, rq_wdelta = 1, rq_wchg = 1. At edge t+3: rq_wchg = 0, rq_wdelta = 0, rq_werr = 0.
- Multi-step: pointer at bin 1, then wptr = 00111 (bin 5) → rq_wdelta = 4, rq_wchg pulses for one cycle, rq_werr = 0.
- Wrap-around: pointer at bin 30 (Gray 10001), then wptr = 00011 (bin 2) → rq_wbin = 2, rq_wdelta = 4, rq_werr = 0.
- Illegal jump: pointer at 0, then wptr = 11110 (bin 20) → rq_wdelta = 20 and rq_werr = 1. rq_werr stays 1 through subsequent legal steps until rrst_n is pulsed low, then 0.
- Depth sweep: repeat the single-step scenario with SYNC_STAGES = 3 and 4 → binary outputs change exactly 4 and 5 edges after the wptr change. Elaboration with SYNC_STAGES = 1 must fail.
